// File: rtl/mmu_responder.sv
// mmu_responder: single-outstanding memory responder with a fixed request-to-response latency.
// Define MMU_ALIGN_CHECK_EN to flag misaligned word accesses on align_err.
module mmu_responder #(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_mmu,
  input  logic        write_mmu,
  input  logic        byte_select_mmu,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        align_err
);
  localparam int         IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic       ONE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [IDX_W+1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             byte_q, byte_d;
  logic             store_q, store_d;

  logic [31:0]      mem [MEM_WORDS];

  logic             req;
  logic             finish;
  logic             mem_we;
  logic [IDX_W+1:0] cur_addr;
  logic [31:0]      cur_wdata;
  logic             cur_byte;
  logic             cur_store;
  logic [IDX_W-1:0] cur_idx;
  logic [1:0]       cur_lane;
  logic [31:0]      cur_word;
  logic [31:0]      wr_word;
  logic             unused_addr_hi;

  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic is_byte,
                                           input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [31:0] ext;
    b   = word[{lane, 3'b000} +: 8];
    ext = b;
    return is_byte ? ext : word;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic is_byte, input logic [1:0] lane);
    logic [31:0] w;
    w = is_byte ? old : wd;
    if (is_byte) w[{lane, 3'b000} +: 8] = wd[7:0];
    return w;
  endfunction

  assign req            = read_mmu | write_mmu;
  assign req_ready      = (state_q == IDLE);
  assign stall          = req & ~req_ready;
  assign unused_addr_hi = ^addr[31:IDX_W+2];

  // The accepting cycle uses the live inputs so LATENCY=1 can finish without a latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr  = addr[IDX_W+1:0];
      cur_wdata = wdata;
      cur_byte  = byte_select_mmu;
      cur_store = write_mmu;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_byte  = byte_q;
      cur_store = store_q;
    end
  end

  assign cur_idx  = cur_addr[IDX_W+1:2];
  assign cur_lane = cur_addr[1:0];
  assign cur_word = mem[cur_idx];
  assign wr_word  = store_merge(cur_word, cur_wdata, cur_byte, cur_lane);

`ifdef MMU_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;
  logic misalign;
  assign misalign  = ~cur_byte & (cur_addr[1:0] != 2'b00);
  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    byte_d       = byte_q;
    store_d      = store_q;
    resp_valid_d = 1'b0;
    rdata_d      = 32'd0;
    finish       = 1'b0;
`ifdef MMU_ALIGN_CHECK_EN
    align_err_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr[IDX_W+1:0];
          wdata_d = wdata;
          byte_d  = byte_select_mmu;
          store_d = write_mmu;
          if (ONE_CYCLE) begin
            finish = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) finish = 1'b1;
        else               cnt_d  = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Entering RESP: stores commit on this edge, loads capture their result.
    if (finish) begin
      state_d      = RESP;
      cnt_d        = 4'd0;
      resp_valid_d = 1'b1;
      rdata_d      = cur_store ? 32'd0 : load_fmt(cur_word, cur_byte, cur_lane);
`ifdef MMU_ALIGN_CHECK_EN
      align_err_d  = misalign;
`endif
    end
  end

  assign mem_we = finish & cur_store & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
`ifdef MMU_ALIGN_CHECK_EN
      align_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
`ifdef MMU_ALIGN_CHECK_EN
      align_err_q  <= align_err_d;
`endif
    end
  end

  // Request copy and memory array carry no reset; memory contents survive rst_n.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    byte_q  <= byte_d;
    store_q <= store_d;
    if (mem_we) mem[cur_idx] <= wr_word;
  end

  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
endmodule
